// File: rtl/ram_matrix_loader.sv
// rtl/ram_matrix_loader.sv - write-side sequencer filling the 8x8 matrix RAM from a valid/ready word stream
// One frame of 64 words per start; fill order (row- or column-major) is latched with start.
module ram_matrix_loader #(
  parameter int SIZE = 16
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            start,
  input  logic            col_major,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] W_data,
  output logic [2:0]      Wi_address,
  output logic [2:0]      Wj_address,
  output logic            Wen,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cnt;
  logic       order_col;
  logic       accept;

  // Acceptance is derived from the state register only, so in_ready has no
  // combinational path from in_valid.
  assign accept = in_valid && (state == LOAD);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (cnt == 7'd63)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 7'd0;
      order_col  <= 1'b0;
      Wen        <= 1'b0;
      W_data     <= '0;
      Wi_address <= 3'd0;
      Wj_address <= 3'd0;
    end else begin
      state <= state_nxt;
      Wen   <= accept;
      if ((state == IDLE) && start) begin
        cnt       <= 7'd0;
        order_col <= col_major;
      end
      // Addresses and data hold between accepts; only Wen drops in gap cycles.
      if (accept) begin
        W_data <= in_data;
        cnt    <= cnt + 7'd1;
        if (order_col) begin
          Wi_address <= cnt[2:0];
          Wj_address <= cnt[5:3];
        end else begin
          Wi_address <= cnt[5:3];
          Wj_address <= cnt[2:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_matrix_loader.sv
// tb/tb_ram_matrix_loader.sv - scoreboard bench for ram_matrix_loader
module tb_ram_matrix_loader;

  localparam int SIZE = 16;

  logic            clock;
  logic            rst;
  logic            start;
  logic            col_major;
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] W_data;
  logic [2:0]      Wi_address;
  logic [2:0]      Wj_address;
  logic            Wen;
  logic            busy;
  logic            done;

  ram_matrix_loader #(.SIZE(SIZE)) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .col_major  (col_major),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .W_data     (W_data),
    .Wi_address (Wi_address),
    .Wj_address (Wj_address),
    .Wen        (Wen),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [SIZE-1:0] d;
    logic [2:0]      i;
    logic [2:0]      j;
  } wr_t;

  wr_t             exp_q[$];
  logic [SIZE-1:0] mem[8][8];
  int              checks   = 0;
  int              failures = 0;
  int              wr_cnt   = 0;
  int              done_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every Wen must match the oldest accepted word.
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (Wen === 1'b1) begin
      wr_cnt++;
      mem[Wi_address][Wj_address] = W_data;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_wen", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("w_data", 32'(W_data), 32'(e.d));
        check_eq("wi_address", 32'(Wi_address), 32'(e.i));
        check_eq("wj_address", 32'(Wj_address), 32'(e.j));
      end
    end
  end

  // Starts a frame from IDLE; returns at posedge+1 with the DUT in LOAD.
  task automatic do_start(input logic col);
    @(posedge clock); #1;
    start     = 1'b1;
    col_major = col;
    wr_cnt    = 0;
    done_cnt  = 0;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("ready_after_start", 32'(in_ready), 32'd1);
    check_eq("busy_after_start", 32'(busy), 32'd1);
  endtask

  // mode 0: valid every cycle; mode 1: valid 1,0,0 pattern;
  // mode 2: valid every cycle with a start pulse and col_major flip from word 10.
  task automatic feed(input logic col, input int n, input int mode, input logic [SIZE-1:0] base);
    int   k;
    int   cyc;
    logic v;
    wr_t  e;
    k   = 0;
    cyc = 0;
    while (k < n) begin
      if (cyc > 1000) begin
        check_eq("feed_timeout", 32'(k), 32'(n));
        break;
      end
      v         = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      in_valid  = v;
      in_data   = base + SIZE'(k);
      start     = (mode == 2) && (k == 10);
      col_major = ((mode == 2) && (k >= 10)) ? ~col : col;
      #1;
      if (v) begin
        if (in_ready !== 1'b1) begin
          check_eq("ready_in_load", 32'(in_ready), 32'd1);
          break;
        end
        e.d = base + SIZE'(k);
        e.i = col ? 3'(k % 8) : 3'(k / 8);
        e.j = col ? 3'(k / 8) : 3'(k % 8);
        exp_q.push_back(e);
        k++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    col_major = col;
  endtask

  // Called at posedge+1 just after the 64th accept: DUT should be in DONE.
  task automatic end_frame(input string tag);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_wen_last"}, 32'(Wen), 32'd1);
    @(negedge clock); #1;
    check_eq({tag, "_writes"}, 32'(wr_cnt), 32'd64);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    col_major = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_wen", 32'(Wen), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wdata", 32'(W_data), 32'd0);
    check_eq("rst_addr", {26'd0, Wi_address, Wj_address}, 32'd0);
    rst = 1'b0;

    // In IDLE a valid word must not be taken.
    in_valid = 1'b1;
    @(posedge clock); #1;
    check_eq("idle_ready", 32'(in_ready), 32'd0);
    check_eq("idle_wen", 32'(Wen), 32'd0);
    in_valid = 1'b0;

    // Row-major, continuous stream.
    do_start(1'b0);
    feed(1'b0, 64, 0, 16'h0000);
    end_frame("row");

    // Column-major, started in the cycle right after done.
    do_start(1'b1);
    feed(1'b1, 64, 0, 16'h0100);
    end_frame("col");
    for (int i = 0; i < 8; i++) begin
      check_eq("col2_read", 32'(mem[i][2]), 32'(16'h0100 + 16'(16 + i)));
    end

    // Gapped stream.
    do_start(1'b0);
    feed(1'b0, 64, 1, 16'h0200);
    end_frame("gap");

    // Mid-frame start pulse and col_major flip are ignored.
    do_start(1'b0);
    feed(1'b0, 64, 2, 16'h0300);
    end_frame("ignore");

    // Reset after 20 accepts, with rst and a valid word in the same cycle.
    do_start(1'b1);
    feed(1'b1, 20, 0, 16'h0400);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hdead;
    @(posedge clock); #1;
    check_eq("abort_wen", 32'(Wen), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd0);
    check_eq("abort_addr", {26'd0, Wi_address, Wj_address}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clock); #1;
    check_eq("abort_writes", 32'(wr_cnt), 32'd20);
    check_eq("abort_queue", 32'(exp_q.size()), 32'd0);

    // Fresh frame after the abort restarts at (0,0).
    do_start(1'b0);
    feed(1'b0, 64, 0, 16'h0500);
    end_frame("restart");

    @(posedge clock); #1;
    check_eq("final_idle_busy", 32'(busy), 32'd0);
    check_eq("final_idle_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
